// File: rtl/multi_delay_timer.sv
// ---------------------------------------------------------------------------
// multi_delay_timer
// CHANNELS independent millisecond delay timers sharing one clock. Each
// channel counts a latched duration D (in ms) with a CLK_PER_MS prescaler,
// then emits a one-cycle done pulse. The channel either returns to idle
// (one-shot) or reloads D and keeps counting (periodic).
//
// Optional feature macro: MULTI_DELAY_TIMER_PAUSE_EN
//   When defined, a global "pause" input freezes all prescalers and ms
//   counters and suppresses done. start and cancel still act while paused.
//
// Ports:
//   clock    in   1                single system clock, posedge
//   reset_n  in   1                asynchronous active-low reset
//   start    in   CHANNELS         per-channel start / retrigger
//   cancel   in   CHANNELS         per-channel abort (wins over start)
//   periodic in   CHANNELS         mode, sampled with start (1 = auto-reload)
//   duration in   CHANNELS*DUR_W   channel i duration at [i*DUR_W +: DUR_W]
//   pause    in   1                (macro only) global freeze
//   done     out  CHANNELS         one-cycle expiry pulse, registered
//   busy     out  CHANNELS         high while the channel is counting
// ---------------------------------------------------------------------------
module multi_delay_timer #(
    parameter int CHANNELS   = 4,
    parameter int CLK_PER_MS = 25000,
    parameter int DUR_W      = 11
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       cancel,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS*DUR_W-1:0] duration,
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    input  logic                      pause,
`endif
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       busy
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    // Prescaler value loaded at start: the first ms lasts CLK_PER_MS cycles
    // and the final observation of ms==0 adds one cycle, giving D*CLK_PER_MS+1.
    localparam logic [PW-1:0] PRE_TOP = PW'(CLK_PER_MS - 1);
    // Periodic reload drops one cycle so later periods are exactly
    // D*CLK_PER_MS. With a single-cycle ms there is no prescaler slack, so
    // the cycle is removed from the ms counter instead.
    localparam bit            ONE_CLK = (CLK_PER_MS == 1);
    localparam logic [PW-1:0] PRE_RLD = ONE_CLK ? '0 : PW'(CLK_PER_MS - 2);

    logic [CHANNELS-1:0] r_state;
    logic [CHANNELS-1:0] r_done;
    logic [CHANNELS-1:0] r_per;
    logic [DUR_W-1:0]    r_dur  [CHANNELS];
    logic [DUR_W-1:0]    r_ms   [CHANNELS];
    logic [PW-1:0]       r_pres [CHANNELS];

    logic                w_pause;
    logic [CHANNELS-1:0] w_run;
    logic [CHANNELS-1:0] w_expire;

`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Per-channel advance/expiry decode; expiry is the first edge that sees ms==0.
    always_comb begin
        w_run    = '0;
        w_expire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_state[i] == ST_COUNT) begin
                w_run[i]    = ~w_pause;
                w_expire[i] = ~w_pause & (r_ms[i] == '0);
            end else begin
                w_run[i]    = 1'b0;
                w_expire[i] = 1'b0;
            end
        end
    end

    // Channel state, counters, latched fields and registered done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= '0;
            r_done  <= '0;
            r_per   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_dur[i]  <= '0;
                r_ms[i]   <= '0;
                r_pres[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_done[i] <= 1'b0;
                if (cancel[i]) begin
                    // Abort without a pulse, even on the would-be expiry edge.
                    r_state[i] <= ST_IDLE;
                    r_ms[i]    <= '0;
                    r_pres[i]  <= '0;
                end else begin
                    if (w_expire[i]) begin
                        r_done[i] <= 1'b1;
                    end
                    if (start[i]) begin
                        // A zero duration always behaves as one-shot.
                        r_state[i] <= ST_COUNT;
                        r_dur[i]   <= duration[i*DUR_W +: DUR_W];
                        r_per[i]   <= periodic[i] & (duration[i*DUR_W +: DUR_W] != '0);
                        r_ms[i]    <= duration[i*DUR_W +: DUR_W];
                        r_pres[i]  <= PRE_TOP;
                    end else if (w_expire[i]) begin
                        if (r_per[i]) begin
                            r_ms[i]   <= ONE_CLK ? (r_dur[i] - DUR_W'(1)) : r_dur[i];
                            r_pres[i] <= PRE_RLD;
                        end else begin
                            r_state[i] <= ST_IDLE;
                        end
                    end else if (w_run[i]) begin
                        // ms is non-zero here (zero would have expired), so no wrap.
                        if (r_pres[i] == '0) begin
                            r_pres[i] <= PRE_TOP;
                            r_ms[i]   <= r_ms[i] - DUR_W'(1);
                        end else begin
                            r_pres[i] <= r_pres[i] - PW'(1);
                        end
                    end
                end
            end
        end
    end

    assign done = r_done;
    assign busy = r_state;

endmodule

// File: tb/tb_multi_delay_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_delay_timer
// Directed bench for multi_delay_timer with CHANNELS=4, CLK_PER_MS=4,
// DUR_W=11. "+k" below means the outputs observed 1 ns after the k-th
// rising edge following the edge that sampled start (that edge is +0).
// Expected values are hand-computed from D*CLK_PER_MS+1 and friends.
// ---------------------------------------------------------------------------
module tb_multi_delay_timer;

    localparam int CH  = 4;
    localparam int CPM = 4;
    localparam int DW  = 11;

    logic              clock;
    logic              reset_n;
    logic [CH-1:0]     start;
    logic [CH-1:0]     cancel;
    logic [CH-1:0]     periodic;
    logic [CH*DW-1:0]  duration;
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    logic              pause;
`endif
    logic [CH-1:0]     done;
    logic [CH-1:0]     busy;

    int n_assert = 0;
    int n_fail   = 0;

    multi_delay_timer #(
        .CHANNELS   (CH),
        .CLK_PER_MS (CPM),
        .DUR_W      (DW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .cancel   (cancel),
        .periodic (periodic),
        .duration (duration),
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
        .pause    (pause),
`endif
        .done     (done),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at +%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic set_dur(input int ch, input int d);
        duration[ch*DW +: DW] = DW'(d);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = '0;
        cancel   = '0;
        periodic = '0;
        duration = '0;
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
        pause    = 1'b0;
`endif
        #2;
        chk("reset_done", 0, |done, 1'b0);
        chk("reset_busy", 0, |busy, 1'b0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();

        // Ch0 one-shot D=3: done at +13 only, busy through +12.
        set_dur(0, 3);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("s1_busy", 0, busy[0], 1'b1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("s1_done", k, done[0], k == 13);
            chk("s1_busy", k, busy[0], k < 13);
        end

        // Ch1 periodic D=2 with cancel at +20, alongside ch2 D=5 retriggered
        // at +10 with D=1 (also shows the channels do not disturb each other).
        set_dur(1, 2);
        set_dur(2, 5);
        periodic[1] = 1'b1;
        start[1] = 1'b1;
        start[2] = 1'b1;
        tick();
        start = '0;
        periodic = '0;
        for (int k = 1; k <= 30; k++) begin
            cancel[1] = (k == 20);
            start[2]  = (k == 10);
            if (k == 10) set_dur(2, 1);
            tick();
            chk("s2_done1", k, done[1], (k == 9) || (k == 17));
            chk("s2_busy1", k, busy[1], k < 20);
            chk("s3_done2", k, done[2], k == 15);
            chk("s3_busy2", k, busy[2], k < 15);
        end
        cancel = '0;
        start  = '0;

        // Ch3 start and cancel together: stays idle, no done.
        set_dur(3, 1);
        start[3]  = 1'b1;
        cancel[3] = 1'b1;
        tick();
        start = '0;
        cancel = '0;
        for (int k = 0; k <= 6; k++) begin
            chk("s4_busy3", k, busy[3], 1'b0);
            chk("s4_done3", k, done[3], 1'b0);
            tick();
        end

        // Ch0 D=0 (periodic requested but ignored): done at +1, then idle.
        set_dur(0, 0);
        periodic[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        start = '0;
        periodic = '0;
        chk("s4_d0_busy", 0, busy[0], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("s4_d0_done", k, done[0], k == 1);
            chk("s4_d0_busy", k, busy[0], 1'b0);
        end

        // Ch0 D=1 restarted on its own expiry edge (+5): pulse at +5 and +10.
        set_dur(0, 1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            start[0] = (k == 5);
            tick();
            chk("s5_done", k, done[0], (k == 5) || (k == 10));
            chk("s5_busy", k, busy[0], k < 10);
        end
        start = '0;

        // Ch0 D=4 with reset asserted at +6; then a start right after release.
        set_dur(0, 4);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (6) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("s6_async_busy", 6, busy[0], 1'b0);
        chk("s6_async_done", 6, done[0], 1'b0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        set_dur(1, 1);
        start[1] = 1'b1;
        tick();
        start = '0;
        chk("s6_first_start", 0, busy[1], 1'b1);
        chk("s6_idle0", 0, busy[0], 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("s6_done0", k, done[0], 1'b0);
            chk("s6_done1", k, done[1], k == 5);
        end

`ifdef MULTI_DELAY_TIMER_PAUSE_EN
        // Ch0 D=3 paused for 7 edges (+4..+10): done moves from +13 to +20.
        set_dur(0, 3);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            pause = (k >= 4) && (k <= 10);
            tick();
            chk("s7_done", k, done[0], k == 20);
            chk("s7_busy", k, busy[0], k < 20);
        end
        pause = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
